// File: rtl/pipe_pkg.sv
// Shared definitions for the receive-side pipeline FIFO.
// Default sizes and the pointer-width helper used by pipe_rx_fifo and pipe_fifo_ptr.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DROPCNT_W     = 16;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_fifo_ptr.sv
// Wrap-bit FIFO pointer: a PW-bit counter with increment enable.
// The MSB is the wrap bit; the low PW-1 bits index the storage array.
// The counter wraps naturally at 2**PW.
module pipe_fifo_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Pointer register: sync active-low reset, advance by one when enabled.
    always_ff @(posedge clk) begin
        // NOTE: nonblocking so every flop samples pre-edge values regardless of process order.
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule : pipe_fifo_ptr

// File: rtl/pipe_rx_fifo.sv
// Receive-side circular FIFO placed after the valid/data pipeline.
// Upstream cannot be stalled, so beats arriving while full are dropped and flagged
// through a sticky overflow bit. The head entry is offered over valid/ready.
// Optional feature macro PIPE_RX_FIFO_DROPCNT_EN adds a saturating 16-bit drop counter.
module pipe_rx_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef PIPE_RX_FIFO_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0]       drop_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    // Status derived from the pointer registers.
    assign m_valid = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign pop  = m_valid & m_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Head entry is gated to zero whenever the FIFO is empty.
    assign m_data = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

    pipe_fifo_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    pipe_fifo_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage write at the write index on every accepted beat.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; empty/valid is tracked entirely by the pointers.
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Sticky overflow: a drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef PIPE_RX_FIFO_DROPCNT_EN
    // Saturating drop counter; a drop coinciding with a clear restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_cnt <= DROPCNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROPCNT_W'(1);
            end
        end else if (clr_ovf) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule : pipe_rx_fifo

// File: tb/tb_pipe_rx_fifo.sv
// Self-checking bench for pipe_rx_fifo (WIDTH=8, DEPTH=4).
// A negedge monitor keeps a queue of expected beats and compares every pop;
// scenario tasks check status outputs at chosen points.
module tb_pipe_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       count;
    logic             full;
    logic             overflow;
    logic             clr_ovf;
`ifdef PIPE_RX_FIFO_DROPCNT_EN
    logic [15:0]      drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;
    logic [WIDTH-1:0] sb_q[$];

    pipe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
`ifdef PIPE_RX_FIFO_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inspects pre-edge state, pops expected data, queues accepted beats.
    always @(negedge clk) begin
        int  sz;
        bit  exp_pop;
        sz = sb_q.size();
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            exp_pop = (sz > 0) && m_ready;
            n_checks++;
            if (m_valid !== (sz > 0)) begin
                n_fail++;
                $display("FAIL mon_valid: got %b want %b", m_valid, (sz > 0));
            end
            n_checks++;
            if (count !== 3'(sz)) begin
                n_fail++;
                $display("FAIL mon_count: got %0d want %0d", count, sz);
            end
            if (exp_pop) begin
                n_checks++;
                if (m_data !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL mon_data: got %h want %h", m_data, sb_q[0]);
                end
                void'(sb_q.pop_front());
                n_popped++;
            end
            if (in_valid && (sz < DEPTH || exp_pop)) begin
                sb_q.push_back(in_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [WIDTH-1:0] base, input int n);
        m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + WIDTH'(i);
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        m_ready = 1'b1;
        while (m_valid === 1'b1 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: m_valid %b queue %0d after %0d cycles, want 0/0", m_valid, sb_q.size(), cyc);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        tick(2);
        n_checks++;
        if (m_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || m_data !== 8'h00 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid %b count %0d ovf %b data %h full %b, want all 0",
                     m_valid, count, overflow, m_data, full);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(1);
        in_valid = 1'b0;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push: valid %b data %h count %0d, want 1 a5 1", m_valid, m_data, count);
        end
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || m_data !== 8'h00 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: count %0d data %h valid %b, want 0 00 0", count, m_data, m_valid);
        end
    endtask

    task automatic test_fill_drop();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            tick(1);
            if (i == 4) begin
                n_checks++;
                if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill4: full %b count %0d ovf %b, want 1 4 0", full, count, overflow);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (overflow !== 1'b1 || count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL drop5: ovf %b count %0d, want 1 4", overflow, count);
                end
            end
        end
        in_valid = 1'b0;
`ifdef PIPE_RX_FIFO_DROPCNT_EN
        n_checks++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_cnt_two: got %0d want 2", drop_cnt);
        end
`endif
        drain();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        // Drop and clear in the same cycle: the drop wins.
        fill(8'h20, 4);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        clr_ovf  = 1'b1;
        tick(1);
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_vs_clr: ovf %b want 1", overflow);
        end
`ifdef PIPE_RX_FIFO_DROPCNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_cnt_reload: got %0d want 1", drop_cnt);
        end
`endif
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf: got %b want 0", overflow);
        end
`ifdef PIPE_RX_FIFO_DROPCNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL drop_cnt_clr: got %0d want 0", drop_cnt);
        end
`endif
        drain();
    endtask

    task automatic test_full_push_pop();
        fill(8'h10, 4);
        n_checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fpp_fill: count %0d full %b, want 4 1", count, full);
        end
        in_valid = 1'b1;
        in_data  = 8'h14;
        m_ready  = 1'b1;
        tick(1);
        in_valid = 1'b0;
        m_ready  = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || m_data !== 8'h11) begin
            n_fail++;
            $display("FAIL fpp_swap: count %0d ovf %b head %h, want 4 0 11", count, overflow, m_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        start   = n_popped;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            tick(1);
        end
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL stream: count %0d ovf %b, want 1 0", count, overflow);
        end
        drain();
        n_checks++;
        if (n_popped - start != 20) begin
            n_fail++;
            $display("FAIL stream_pops: got %0d want 20", n_popped - start);
        end
    endtask

    task automatic test_mid_reset();
        fill(8'h40, 5);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_ovf_pre: got %b want 1", overflow);
        end
        m_ready = 1'b1;
        tick(2);
        m_ready = 1'b0;
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL mr_pre: count %0d want 2", count);
        end
        fill(8'h60, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_checks++;
        if (count !== 3'd0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count %0d valid %b ovf %b, want 0 0 0", count, m_valid, overflow);
        end
`ifdef PIPE_RX_FIFO_DROPCNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mr_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        fill(8'h77, 1);
        n_checks++;
        if (m_data !== 8'h77 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL mr_next: head %h count %0d, want 77 1", m_data, count);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drop();
        test_full_push_pop();
        test_back_to_back();
        test_mid_reset();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_rx_fifo
